// File: rtl/sevenseg_pkg.sv
// Shared glyph table, segment constants and the active-level transform for the seven-segment driver.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package sevenseg_pkg;

    // Active-low glyphs: bit7 = dp (1 = off), bits 6:0 = g..a.
    localparam logic [7:0] GLYPH_0 = 8'hC0;
    localparam logic [7:0] GLYPH_1 = 8'hF9;
    localparam logic [7:0] GLYPH_2 = 8'hA4;
    localparam logic [7:0] GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h92;
    localparam logic [7:0] GLYPH_6 = 8'h82;
    localparam logic [7:0] GLYPH_7 = 8'hF8;
    localparam logic [7:0] GLYPH_8 = 8'h80;
    localparam logic [7:0] GLYPH_9 = 8'h90;
    localparam logic [7:0] GLYPH_A = 8'h88;
    localparam logic [7:0] GLYPH_B = 8'h83;
    localparam logic [7:0] GLYPH_C = 8'hC6;
    localparam logic [7:0] GLYPH_D = 8'hA1;
    localparam logic [7:0] GLYPH_E = 8'h86;
    localparam logic [7:0] GLYPH_F = 8'h8E;

    localparam logic [7:0] SEG_OFF_AL = 8'hFF;
    localparam int         DP_BIT     = 7;

    // Everything internal is active-low; flip the byte for active-high boards.
    function automatic logic [7:0] to_level(input logic [7:0] al_byte, input bit active_low);
        return active_low ? al_byte : ~al_byte;
    endfunction

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Display bus between the status datapath (master) and the scan driver (slave).
// Latency: none (wires only).
// Backpressure: none; load is a strobe that the driver always accepts.
interface sevenseg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic [7:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic [SLOT_W-1:0]       slot_idx;

    modport master (output load, value, dp, blank, input seg, an, slot_idx);
    modport slave  (input load, value, dp, blank, output seg, an, slot_idx);

endinterface

// File: rtl/sevenseg_glyph_rom.sv
// Combinational hex digit + dp to active-low seven-segment glyph.
// Latency: 0 cycles (pure combinational).
// Backpressure: not applicable.
module sevenseg_glyph_rom
    import sevenseg_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       dp_i,
    output logic [7:0] glyph_o
);

    // Table lookup, then drop the dp bit low when the point is lit.
    always_comb begin
        glyph_o = GLYPH_0;
        case (digit_i)
            4'h0: glyph_o = GLYPH_0;
            4'h1: glyph_o = GLYPH_1;
            4'h2: glyph_o = GLYPH_2;
            4'h3: glyph_o = GLYPH_3;
            4'h4: glyph_o = GLYPH_4;
            4'h5: glyph_o = GLYPH_5;
            4'h6: glyph_o = GLYPH_6;
            4'h7: glyph_o = GLYPH_7;
            4'h8: glyph_o = GLYPH_8;
            4'h9: glyph_o = GLYPH_9;
            4'hA: glyph_o = GLYPH_A;
            4'hB: glyph_o = GLYPH_B;
            4'hC: glyph_o = GLYPH_C;
            4'hD: glyph_o = GLYPH_D;
            4'hE: glyph_o = GLYPH_E;
            default: glyph_o = GLYPH_F;
        endcase
        glyph_o[DP_BIT] = ~dp_i;
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with shadow load, guard interval, dp and blanking; SEVENSEG_LZ_SUPPRESS_EN adds leading-zero suppression.
// Latency: seg/an are registered, 1 cycle after the counter/shadow state they show.
// Backpressure: none; load is captured on any edge where it is high.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int GUARD_CYCLES = 2,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input logic                 clock,
    input logic                 reset,
    sevenseg_scan_driver_if.slave bus
);

    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam logic [7:0]            SEG_OFF = to_level(SEG_OFF_AL, ACTIVE_LOW);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   dp_q, blank_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   an_on;
    logic [7:0]              rom_glyph, glyph_al;
    logic                    in_guard;

    // Shadow registers: the whole frame is replaced in one edge so digits never tear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            dp_q    <= '0;
            blank_q <= '0;
        end else if (bus.load) begin
            value_q <= bus.value;
            dp_q    <= bus.dp;
            blank_q <= bus.blank;
        end
    end

    // Slot timing: cnt wraps every SCAN_DIV cycles and steps the scanned digit.
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        slot_d = slot_q;
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d  = '0;
            slot_d = (slot_q == SLOT_W'(NUM_DIGITS - 1)) ? '0 : slot_q + 1'b1;
        end
    end

    // Counter and slot registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            slot_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
        end
    end

    sevenseg_glyph_rom u_glyph_rom (
        .digit_i (value_q[4*slot_q +: 4]),
        .dp_i    (dp_q[slot_q]),
        .glyph_o (rom_glyph)
    );

`ifdef SEVENSEG_LZ_SUPPRESS_EN
    logic lz_found;

    // Walk down from the top digit; every digit above the first nonzero one is dark. Digit 0 never is.
    always_comb begin
        lz_mask  = '0;
        lz_found = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (value_q[4*i +: 4] != 4'h0) lz_found = 1'b1;
            lz_mask[i] = ~lz_found;
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign in_guard = int'(cnt_q) < GUARD_CYCLES;

    // Next output byte: glyph with suppression/blanking, then guard forces everything dark.
    always_comb begin
        glyph_al = rom_glyph;
        if (lz_mask[slot_q]) glyph_al[6:0] = 7'h7F;
        if (blank_q[slot_q]) glyph_al = SEG_OFF_AL;
        an_on = NUM_DIGITS'(1) << slot_q;
        if (in_guard) begin
            seg_d = SEG_OFF;
            an_d  = AN_OFF;
        end else begin
            seg_d = to_level(glyph_al, ACTIVE_LOW);
            an_d  = ACTIVE_LOW ? ~an_on : an_on;
        end
    end

    // Output register: reset drives the pins dark immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign bus.seg      = seg_q;
    assign bus.an       = an_q;
    assign bus.slot_idx = slot_q;

endmodule
